// File: rtl/src_rate_controller.sv
// Rate-change sequencer for the SRC coefficient path: maps timebase selects to
// interpolation/decimation rate pairs and applies them via a drain/load/settle sequence.
module src_rate_controller #(
    parameter int unsigned STARTUP_CYCLES = 63,
    parameter int unsigned FLUSH_CYCLES   = 8,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter logic [2:0]  DEFAULT_SEL    = 3'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] tb_sel,
    input  logic       tb_req,
    output logic       tb_ack,
    output logic       tb_err,
    output logic       busy,
    output logic [2:0] cur_sel,
    output logic [2:0] int_rate,
    output logic       int_valid,
    output logic [2:0] dec_rate,
    output logic       dec_valid,
    output logic       src_flush
);

    localparam int unsigned CNT_MAX_SF =
        (STARTUP_CYCLES > FLUSH_CYCLES) ? STARTUP_CYCLES : FLUSH_CYCLES;
    localparam int unsigned CNT_MAX =
        (CNT_MAX_SF > SETTLE_CYCLES) ? CNT_MAX_SF : SETTLE_CYCLES;
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [2:0] ST_STARTUP = 3'd0;
    localparam logic [2:0] ST_FLUSH   = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_ACTIVE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       target_q, target_d;
    logic             pend_vld_q, pend_vld_d;
    logic [2:0]       pend_sel_q, pend_sel_d;
    logic             first_q, first_d;

    logic             ack_d, err_d, busy_d, flush_d, valid_d;
    logic [2:0]       int_rate_d, dec_rate_d, cur_sel_d;
    logic [2:0]       map_int, map_dec;
    logic             req_ok, req_bad;

    assign req_ok  = tb_req && !tb_sel[3];
    assign req_bad = tb_req &&  tb_sel[3];

    // Fixed select -> (interpolation, decimation) rate ROM
    always_comb begin
        map_int = 3'd1;
        map_dec = 3'd1;
        case (target_q)
            3'd0:    map_int = 3'd4;
            3'd1:    map_int = 3'd2;
            3'd2:    map_dec = 3'd1;
            default: map_dec = target_q;
        endcase
    end

    // Next-state, counter, pending slot and registered-output next values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        pend_vld_d = pend_vld_q;
        pend_sel_d = pend_sel_q;
        first_d    = first_q;
        ack_d      = 1'b0;
        err_d      = req_bad;
        flush_d    = src_flush;
        valid_d    = int_valid;
        int_rate_d = int_rate;
        dec_rate_d = dec_rate;
        cur_sel_d  = cur_sel;

        // Requests outside ACTIVE wait in the single pending slot, latest wins
        if (state_q != ST_ACTIVE && req_ok) begin
            pend_vld_d = 1'b1;
            pend_sel_d = tb_sel[2:0];
        end

        case (state_q)
            ST_STARTUP: begin
                if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
                    state_d  = ST_FLUSH;
                    cnt_d    = '0;
                    target_d = DEFAULT_SEL;
                    flush_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                int_rate_d = map_int;
                dec_rate_d = map_dec;
                cur_sel_d  = target_q;
                state_d    = ST_SETTLE;
                cnt_d      = '0;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    ack_d   = !first_q;
                    first_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                // A fresh request supersedes anything left pending
                if (req_ok) begin
                    pend_vld_d = 1'b0;
                    if (tb_sel[2:0] != cur_sel) begin
                        state_d  = ST_FLUSH;
                        cnt_d    = '0;
                        target_d = tb_sel[2:0];
                        flush_d  = 1'b1;
                        valid_d  = 1'b0;
                    end else begin
                        ack_d = 1'b1;
                    end
                end else if (pend_vld_q) begin
                    pend_vld_d = 1'b0;
                    if (pend_sel_q != cur_sel) begin
                        state_d  = ST_FLUSH;
                        cnt_d    = '0;
                        target_d = pend_sel_q;
                        flush_d  = 1'b1;
                        valid_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_STARTUP;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_STARTUP;
            cnt_q      <= '0;
            target_q   <= DEFAULT_SEL;
            pend_vld_q <= 1'b0;
            pend_sel_q <= 3'd0;
            first_q    <= 1'b1;
            tb_ack     <= 1'b0;
            tb_err     <= 1'b0;
            busy       <= 1'b1;
            cur_sel    <= DEFAULT_SEL;
            int_rate   <= 3'd1;
            dec_rate   <= 3'd1;
            int_valid  <= 1'b0;
            dec_valid  <= 1'b0;
            src_flush  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            pend_vld_q <= pend_vld_d;
            pend_sel_q <= pend_sel_d;
            first_q    <= first_d;
            tb_ack     <= ack_d;
            tb_err     <= err_d;
            busy       <= busy_d;
            cur_sel    <= cur_sel_d;
            int_rate   <= int_rate_d;
            dec_rate   <= dec_rate_d;
            int_valid  <= valid_d;
            dec_valid  <= valid_d;
            src_flush  <= flush_d;
        end
    end

endmodule

// File: tb/tb_src_rate_controller.sv
// Directed self-checking bench for src_rate_controller: startup, change, same-select,
// invalid select, request coalescing and mid-sequence reset.
module tb_src_rate_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tb_sel;
    logic       tb_req;
    logic       tb_ack, tb_err, busy;
    logic [2:0] cur_sel, int_rate, dec_rate;
    logic       int_valid, dec_valid, src_flush;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    src_rate_controller dut (
        .clk       (clk),
        .rst       (rst),
        .tb_sel    (tb_sel),
        .tb_req    (tb_req),
        .tb_ack    (tb_ack),
        .tb_err    (tb_err),
        .busy      (busy),
        .cur_sel   (cur_sel),
        .int_rate  (int_rate),
        .int_valid (int_valid),
        .dec_rate  (dec_rate),
        .dec_valid (dec_valid),
        .src_flush (src_flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next negedge (sampling point) and drop any request strobe
    task automatic next_cycle();
        @(negedge clk);
        tb_req = 1'b0;
    endtask

    task automatic request(input logic [3:0] sel);
        tb_req = 1'b1;
        tb_sel = sel;
    endtask

    // Releases rst and checks the full startup sequence through cycle 95
    task automatic run_startup(input string name);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int cyc = 0; cyc <= 95; cyc++) begin
            next_cycle();
            check($sformatf("%s flush c%0d", name, cyc), 32'(src_flush), 32'((cyc >= 63 && cyc <= 70) ? 1 : 0));
            check($sformatf("%s ival c%0d", name, cyc), 32'(int_valid), 32'((cyc >= 88) ? 1 : 0));
            check($sformatf("%s dval c%0d", name, cyc), 32'(dec_valid), 32'((cyc >= 88) ? 1 : 0));
            check($sformatf("%s busy c%0d", name, cyc), 32'(busy), 32'((cyc < 88) ? 1 : 0));
            check($sformatf("%s ack c%0d", name, cyc), 32'(tb_ack), 32'(0));
            if (cyc == 88) begin
                check($sformatf("%s int_rate", name), 32'(int_rate), 32'(1));
                check($sformatf("%s dec_rate", name), 32'(dec_rate), 32'(1));
                check($sformatf("%s cur_sel", name), 32'(cur_sel), 32'(2));
            end
        end
    endtask

    int ack_cnt;
    int flush_cnt;
    int saw5;

    initial begin
        rst    = 1'b1;
        tb_req = 1'b0;
        tb_sel = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst int_rate", 32'(int_rate), 32'(1));
        check("rst dec_rate", 32'(dec_rate), 32'(1));
        check("rst valids", 32'({int_valid, dec_valid}), 32'(0));
        check("rst flush", 32'(src_flush), 32'(0));
        check("rst busy", 32'(busy), 32'(1));
        check("rst ack_err", 32'({tb_ack, tb_err}), 32'(0));
        check("rst cur_sel", 32'(cur_sel), 32'(2));

        run_startup("startup");

        // Single change to select 4
        request(4'd4);
        for (int k = 1; k <= 26; k++) begin
            next_cycle();
            check($sformatf("chg busy k%0d", k), 32'(busy), 32'((k <= 25) ? 1 : 0));
            check($sformatf("chg flush k%0d", k), 32'(src_flush), 32'((k <= 8) ? 1 : 0));
            check($sformatf("chg valid k%0d", k), 32'(int_valid & dec_valid), 32'((k == 26) ? 1 : 0));
            check($sformatf("chg ack k%0d", k), 32'(tb_ack), 32'((k == 26) ? 1 : 0));
        end
        check("chg int_rate", 32'(int_rate), 32'(1));
        check("chg dec_rate", 32'(dec_rate), 32'(4));
        check("chg cur_sel", 32'(cur_sel), 32'(4));
        next_cycle();
        check("chg ack drop", 32'(tb_ack), 32'(0));

        // Same-select request acknowledges without a flush
        request(4'd4);
        next_cycle();
        check("same ack", 32'(tb_ack), 32'(1));
        check("same flush", 32'(src_flush), 32'(0));
        check("same valid", 32'(int_valid & dec_valid), 32'(1));
        check("same busy", 32'(busy), 32'(0));
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            check($sformatf("same quiet k%0d", k), 32'({tb_ack, src_flush, busy}), 32'(0));
        end

        // Invalid select
        request(4'd9);
        next_cycle();
        check("inv err", 32'(tb_err), 32'(1));
        check("inv ack", 32'(tb_ack), 32'(0));
        check("inv valid", 32'(int_valid & dec_valid), 32'(1));
        check("inv busy", 32'(busy), 32'(0));
        check("inv rates", 32'({int_rate, dec_rate}), 32'({3'd1, 3'd4}));
        check("inv cur_sel", 32'(cur_sel), 32'(4));
        next_cycle();
        check("inv err drop", 32'(tb_err), 32'(0));
        check("inv still idle", 32'({busy, src_flush}), 32'(0));

        // Coalescing: 0, then 5 during FLUSH, then 7 during SETTLE
        ack_cnt = 0; flush_cnt = 0; saw5 = 0;
        request(4'd0);
        for (int k = 1; k <= 56; k++) begin
            next_cycle();
            ack_cnt   += int'(tb_ack);
            flush_cnt += int'(src_flush);
            if (cur_sel == 3'd5 || dec_rate == 3'd5) saw5 = 1;
            if (k == 26) begin
                check("coal1 valid", 32'(int_valid & dec_valid), 32'(1));
                check("coal1 ack", 32'(tb_ack), 32'(1));
                check("coal1 rates", 32'({int_rate, dec_rate}), 32'({3'd4, 3'd1}));
                check("coal1 cur_sel", 32'(cur_sel), 32'(0));
            end
            if (k == 27) begin
                check("coal reflush", 32'(src_flush), 32'(1));
                check("coal valid drop", 32'(int_valid | dec_valid), 32'(0));
                check("coal busy", 32'(busy), 32'(1));
            end
            if (k == 52) begin
                check("coal2 valid", 32'(int_valid & dec_valid), 32'(1));
                check("coal2 ack", 32'(tb_ack), 32'(1));
                check("coal2 rates", 32'({int_rate, dec_rate}), 32'({3'd1, 3'd7}));
                check("coal2 cur_sel", 32'(cur_sel), 32'(7));
            end
            if (k == 3)  request(4'd5);
            if (k == 15) request(4'd7);
        end
        check("coal ack count", 32'(ack_cnt), 32'(2));
        check("coal flush cycles", 32'(flush_cnt), 32'(16));
        check("coal sel5 applied", 32'(saw5), 32'(0));
        check("coal idle", 32'(busy), 32'(0));

        // Reset during SETTLE with a request pending
        request(4'd3);
        for (int k = 1; k <= 14; k++) begin
            next_cycle();
            if (k == 12) request(4'd6);
        end
        rst = 1'b1;
        next_cycle();
        check("mrst valids", 32'({int_valid, dec_valid}), 32'(0));
        check("mrst busy", 32'(busy), 32'(1));
        check("mrst rates", 32'({int_rate, dec_rate}), 32'({3'd1, 3'd1}));
        check("mrst cur_sel", 32'(cur_sel), 32'(2));
        check("mrst flush", 32'(src_flush), 32'(0));
        run_startup("restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
